// File: rtl/fse_pkg.sv
// -----------------------------------------------------------------------------
// fse_pkg
// Shared constants for the FSE LMS adaptation stage: tap count, fixed-point
// formats of the input samples, FSE output and taps, derived product/gradient
// widths, slicer level, centre-tap index and the update FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package fse_pkg;

    localparam int NUM_TAPS   = 9;
    localparam int NBT_IN     = 8;     // S(8,7) T/2 input samples
    localparam int NBF_IN     = 7;
    localparam int NBT_EQ     = 12;    // S(12,9) FSE output
    localparam int NBF_EQ     = 9;
    localparam int NBT_TAPS   = 28;    // S(28,25) taps
    localparam int NBF_TAPS   = 25;

    localparam int MU_SHIFT_DEF   = 12;
    localparam int LEAK_SHIFT_DEF = 16;
    localparam int DEC_LEVEL      = 362;   // ~0.707 in S(12,9)

    // Error is d - y at one extra bit: S(13,9)
    localparam int ERR_W    = NBT_EQ + 1;
    // error x sample product S(21,16) and sum of two products S(22,16)
    localparam int PROD_W   = ERR_W + NBT_IN;
    localparam int PROD_F   = NBF_EQ + NBF_IN;
    localparam int GRAD_W   = PROD_W + 1;
    // Left shift that moves the gradient onto the tap binary point
    localparam int ALIGN_SH = NBF_TAPS - PROD_F;
    // Headroom for w - leak + delta before saturation
    localparam int ACC_W    = GRAD_W + ALIGN_SH + 2;

    localparam int CENTER_TAP = NUM_TAPS / 2;
    localparam int K_W        = $clog2(NUM_TAPS);
    localparam int TAPV_W     = NUM_TAPS * NBT_TAPS;

    // 1.0 in S(NBT_TAPS,NBF_TAPS)
    localparam logic signed [NBT_TAPS-1:0] TAP_ONE =
        {{(NBT_TAPS-NBF_TAPS-1){1'b0}}, 1'b1, {NBF_TAPS{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_COMMIT
    } lms_state_e;

endpackage

// File: rtl/fse_lms_update_if.sv
// -----------------------------------------------------------------------------
// fse_lms_update_if
// Bundle between the FSE side and the LMS adaptation stage.
//   i_is_data_I/Q  T/2 input samples (same as the FSE inputs)
//   i_en           T/2 shift strobe
//   i_sym_valid    symbol strobe, FSE output valid for current delay line
//   i_eq_data_I/Q  FSE output y
//   i_adapt_en     adaptation enable, sampled with i_sym_valid
//   o_taps_I/Q     packed committed taps (tap k at [(k+1)*NBT_TAPS-1 : k*NBT_TAPS])
//   o_err_I/Q      last slicer error S(13,9)
//   o_busy         update in progress
//   o_drop         one-cycle pulse when a symbol strobe is ignored
// Modports: master drives the inputs of the stage, slave is the stage itself.
// -----------------------------------------------------------------------------
interface fse_lms_update_if;
    import fse_pkg::*;

    logic signed [NBT_IN-1:0] i_is_data_I;
    logic signed [NBT_IN-1:0] i_is_data_Q;
    logic                     i_en;
    logic                     i_sym_valid;
    logic signed [NBT_EQ-1:0] i_eq_data_I;
    logic signed [NBT_EQ-1:0] i_eq_data_Q;
    logic                     i_adapt_en;
    logic [TAPV_W-1:0]        o_taps_I;
    logic [TAPV_W-1:0]        o_taps_Q;
    logic signed [ERR_W-1:0]  o_err_I;
    logic signed [ERR_W-1:0]  o_err_Q;
    logic                     o_busy;
    logic                     o_drop;

    modport master (
        output i_is_data_I, i_is_data_Q, i_en, i_sym_valid,
               i_eq_data_I, i_eq_data_Q, i_adapt_en,
        input  o_taps_I, o_taps_Q, o_err_I, o_err_Q, o_busy, o_drop
    );

    modport slave (
        input  i_is_data_I, i_is_data_Q, i_en, i_sym_valid,
               i_eq_data_I, i_eq_data_Q, i_adapt_en,
        output o_taps_I, o_taps_Q, o_err_I, o_err_Q, o_busy, o_drop
    );

endinterface

// File: rtl/fse_lms_tap_upd.sv
// -----------------------------------------------------------------------------
// fse_lms_tap_upd
// Combinational single-tap LMS step: w_new = sat(w [- leak] + mu * e * conj(x)).
//   err_I/Q     slicer error S(13,9)
//   x_I/x_Q     snapshot sample for this tap S(8,7)
//   w_I/w_Q     current working tap S(28,25)
//   w_new_I/Q   updated, saturated tap S(28,25)
// Optional feature: define FSE_LMS_LEAK_EN for leaky LMS, subtracting
// w >>> LEAK_SHIFT every step. Without it LEAK_SHIFT has no effect.
// -----------------------------------------------------------------------------
module fse_lms_tap_upd
    import fse_pkg::*;
#(
    parameter int MU_SHIFT   = MU_SHIFT_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
    input  logic signed [ERR_W-1:0]    err_I,
    input  logic signed [ERR_W-1:0]    err_Q,
    input  logic signed [NBT_IN-1:0]   x_I,
    input  logic signed [NBT_IN-1:0]   x_Q,
    input  logic signed [NBT_TAPS-1:0] w_I,
    input  logic signed [NBT_TAPS-1:0] w_Q,
    output logic signed [NBT_TAPS-1:0] w_new_I,
    output logic signed [NBT_TAPS-1:0] w_new_Q
);

`ifdef FSE_LMS_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    localparam logic signed [ACC_W-1:0] TAP_MAX = (ACC_W'(1) <<< (NBT_TAPS-1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] TAP_MIN = -TAP_MAX - ACC_W'(1);

    function automatic logic signed [NBT_TAPS-1:0] sat_tap(input logic signed [ACC_W-1:0] v);
        logic signed [NBT_TAPS-1:0] r;
        if (v > TAP_MAX)      r = TAP_MAX[NBT_TAPS-1:0];
        else if (v < TAP_MIN) r = TAP_MIN[NBT_TAPS-1:0];
        else                  r = v[NBT_TAPS-1:0];
        return r;
    endfunction

    logic signed [PROD_W-1:0] e_I_x, e_Q_x, x_I_x, x_Q_x;
    logic signed [PROD_W-1:0] p_ii, p_qq, p_qi, p_iq;
    logic signed [GRAD_W-1:0] g_I, g_Q;
    logic signed [ACC_W-1:0]  a_I, a_Q, d_I, d_Q;
    logic signed [ACC_W-1:0]  wx_I, wx_Q, lk_I, lk_Q, acc_I, acc_Q;

    // Operands widened first so the products are formed at full S(21,16)
    assign e_I_x = PROD_W'(err_I);
    assign e_Q_x = PROD_W'(err_Q);
    assign x_I_x = PROD_W'(x_I);
    assign x_Q_x = PROD_W'(x_Q);

    assign p_ii = e_I_x * x_I_x;
    assign p_qq = e_Q_x * x_Q_x;
    assign p_qi = e_Q_x * x_I_x;
    assign p_iq = e_I_x * x_Q_x;

    // e * conj(x)
    assign g_I = GRAD_W'(p_ii) + GRAD_W'(p_qq);
    assign g_Q = GRAD_W'(p_qi) - GRAD_W'(p_iq);

    // Move onto the tap binary point, then apply mu with a flooring shift
    assign a_I = ACC_W'(g_I) <<< ALIGN_SH;
    assign a_Q = ACC_W'(g_Q) <<< ALIGN_SH;
    assign d_I = a_I >>> MU_SHIFT;
    assign d_Q = a_Q >>> MU_SHIFT;

    assign wx_I = ACC_W'(w_I);
    assign wx_Q = ACC_W'(w_Q);
    assign lk_I = LEAK_ON ? (wx_I >>> LEAK_SHIFT) : '0;
    assign lk_Q = LEAK_ON ? (wx_Q >>> LEAK_SHIFT) : '0;

    assign acc_I = wx_I - lk_I + d_I;
    assign acc_Q = wx_Q - lk_Q + d_Q;

    assign w_new_I = sat_tap(acc_I);
    assign w_new_Q = sat_tap(acc_Q);

endmodule

// File: rtl/fse_lms_update.sv
// -----------------------------------------------------------------------------
// fse_lms_update
// LMS coefficient adaptation behind the complex fractionally spaced equalizer.
// Mirrors the FSE T/2 delay line, slices each symbol, forms the complex error
// and updates the taps serially (one tap per clock) through a shared
// fse_lms_tap_upd, then commits all taps to the output buses in one cycle.
//   clk        clock
//   i_reset_n  asynchronous active-low reset
//   bus        fse_lms_update_if.slave (samples, strobes, taps, error, status)
// Optional feature: FSE_LMS_LEAK_EN selects leaky LMS inside fse_lms_tap_upd.
// -----------------------------------------------------------------------------
module fse_lms_update
    import fse_pkg::*;
#(
    parameter int MU_SHIFT   = MU_SHIFT_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
    input  logic               clk,
    input  logic               i_reset_n,
    fse_lms_update_if.slave    bus
);

    localparam logic signed [ERR_W-1:0] DEC_E  = ERR_W'(DEC_LEVEL);
    localparam logic [K_W-1:0]          K_LAST = K_W'(NUM_TAPS-1);

    // y = 0 slices to the positive decision
    function automatic logic signed [ERR_W-1:0] slice_err(input logic signed [NBT_EQ-1:0] y);
        logic signed [ERR_W-1:0] d;
        d = y[NBT_EQ-1] ? -DEC_E : DEC_E;
        return d - ERR_W'(y);
    endfunction

    lms_state_e state, state_nxt;
    logic [K_W-1:0] k;

    logic signed [NBT_IN-1:0]   mir_I  [NUM_TAPS];
    logic signed [NBT_IN-1:0]   mir_Q  [NUM_TAPS];
    logic signed [NBT_IN-1:0]   snap_I [NUM_TAPS];
    logic signed [NBT_IN-1:0]   snap_Q [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] w_I    [NUM_TAPS];
    logic signed [NBT_TAPS-1:0] w_Q    [NUM_TAPS];
    logic [TAPV_W-1:0]          taps_I, taps_Q;
    logic signed [ERR_W-1:0]    e_I, e_Q, err_I, err_Q;
    logic signed [NBT_TAPS-1:0] w_new_I, w_new_Q;
    logic                       drop;
    logic                       err_load, start, step, commit, drop_set;

    assign e_I = slice_err(bus.i_eq_data_I);
    assign e_Q = slice_err(bus.i_eq_data_Q);

    // FSM state register
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_load  = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        drop_set  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // Error is tracked even when adaptation is off
                err_load = bus.i_sym_valid;
                if (bus.i_sym_valid && bus.i_adapt_en) begin
                    start     = 1'b1;
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                step     = 1'b1;
                drop_set = bus.i_sym_valid && bus.i_adapt_en;
                if (k == K_LAST) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit    = 1'b1;
                drop_set  = bus.i_sym_valid && bus.i_adapt_en;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Mirror of the FSE delay line: newest sample enters at index 0
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int j = 0; j < NUM_TAPS; j++) begin
                mir_I[j] <= '0;
                mir_Q[j] <= '0;
            end
        end else if (bus.i_en) begin
            mir_I[0] <= bus.i_is_data_I;
            mir_Q[0] <= bus.i_is_data_Q;
            for (int j = 1; j < NUM_TAPS; j++) begin
                mir_I[j] <= mir_I[j-1];
                mir_Q[j] <= mir_Q[j-1];
            end
        end
    end

    fse_lms_tap_upd #(
        .MU_SHIFT   (MU_SHIFT),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_tap_upd (
        .err_I   (err_I),
        .err_Q   (err_Q),
        .x_I     (snap_I[k]),
        .x_Q     (snap_Q[k]),
        .w_I     (w_I[k]),
        .w_Q     (w_Q[k]),
        .w_new_I (w_new_I),
        .w_new_Q (w_new_Q)
    );

    // Snapshot, working taps, committed taps, error and drop pulse.
    // The snapshot takes the pre-shift mirror, matching the FSE output that
    // the symbol strobe refers to.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            k     <= '0;
            err_I <= '0;
            err_Q <= '0;
            drop  <= 1'b0;
            for (int j = 0; j < NUM_TAPS; j++) begin
                snap_I[j] <= '0;
                snap_Q[j] <= '0;
                w_I[j]    <= (j == CENTER_TAP) ? TAP_ONE : '0;
                w_Q[j]    <= '0;
                taps_I[j*NBT_TAPS +: NBT_TAPS] <= (j == CENTER_TAP) ? TAP_ONE : '0;
                taps_Q[j*NBT_TAPS +: NBT_TAPS] <= '0;
            end
        end else begin
            drop <= drop_set;
            if (err_load) begin
                err_I <= e_I;
                err_Q <= e_Q;
            end
            if (start) begin
                k <= '0;
                for (int j = 0; j < NUM_TAPS; j++) begin
                    snap_I[j] <= mir_I[j];
                    snap_Q[j] <= mir_Q[j];
                end
            end
            if (step) begin
                w_I[k] <= w_new_I;
                w_Q[k] <= w_new_Q;
                k      <= k + K_W'(1);
            end
            // Atomic hand-over so the FSE never sees a half-updated set
            if (commit) begin
                for (int j = 0; j < NUM_TAPS; j++) begin
                    taps_I[j*NBT_TAPS +: NBT_TAPS] <= w_I[j];
                    taps_Q[j*NBT_TAPS +: NBT_TAPS] <= w_Q[j];
                end
            end
        end
    end

    assign bus.o_taps_I = taps_I;
    assign bus.o_taps_Q = taps_Q;
    assign bus.o_err_I  = err_I;
    assign bus.o_err_Q  = err_Q;
    assign bus.o_busy   = (state != ST_IDLE);
    assign bus.o_drop   = drop;

endmodule

// File: doc/fse_lms_update.md
Name: fse_lms_update

Overview:
- LMS coefficient-adaptation stage directly downstream of the complex fractionally spaced equalizer (FSE).
- Consumes the FSE's symbol-rate output and a mirror of its T/2 input delay line.
- Slices each symbol, forms the complex error, and updates the complex taps serially, one tap per clock.
- Presents the packed tap buses that drive the FSE tap inputs, committing them atomically.

Parameters:
- NUM_TAPS, 9, complex taps (matches FSE).
- NBT_IN, 8, input sample width, S(8,7).
- NBF_IN, 7, input sample fraction bits.
- NBT_EQ, 12, FSE output width, S(12,9).
- NBF_EQ, 9, FSE output fraction bits.
- NBT_TAPS, 28, tap width, S(28,25).
- NBF_TAPS, 25, tap fraction bits.
- MU_SHIFT, 12, step size mu = 2^-MU_SHIFT.
- DEC_LEVEL, 362, slicer amplitude in S(NBT_EQ,NBF_EQ) (about 0.707).
- LEAK_SHIFT, 16, leakage factor 2^-LEAK_SHIFT (optional feature only).

Ports:
- clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_is_data_I / i_is_data_Q  in  NBT_IN  T/2 input samples, identical to the FSE inputs.
- i_en  in  1  T/2 shift strobe, identical to the FSE enable.
- i_sym_valid  in  1  symbol strobe; the FSE output is valid for the current delay-line contents.
- i_eq_data_I / i_eq_data_Q  in  NBT_EQ  FSE output y.
- i_adapt_en  in  1  adaptation enable, sampled on i_sym_valid.
- o_taps_I / o_taps_Q  out  NUM_TAPS*NBT_TAPS  packed taps; tap k occupies bits [(k+1)*NBT_TAPS-1 : k*NBT_TAPS].
- o_err_I / o_err_Q  out  NBT_EQ+1  last error, S(13,9).
- o_busy  out  1  update in progress.
- o_drop  out  1  one-cycle pulse when a symbol is ignored.

Behaviour:
- Reset (asynchronous, i_reset_n=0):
  - State IDLE; mirror shifter, snapshot, working taps and o_taps are all cleared.
  - Exception: the centre tap (NUM_TAPS/2) I component resets to 1.0 = 2^NBF_TAPS; its Q component is 0.
  - o_err_I/o_err_Q = 0, o_busy = 0, o_drop = 0.
- Mirror shifter: NUM_TAPS-deep I/Q delay line with the same shift rule as the FSE (i_en=1 shifts in the input at index 0). Its contents always equal the FSE delay line.
- Slicer:
  - d = +DEC_LEVEL when the sign bit of y is 0 (y = 0 slices positive), else -DEC_LEVEL; applied per component.
  - e = d - y at full NBT_EQ+1 width; no saturation is needed.
- FSM IDLE -> UPDATE -> COMMIT -> IDLE:
  - IDLE: on i_sym_valid & i_adapt_en, register e into o_err and snapshot the pre-shift mirror shifter (the value before any same-cycle i_en shift). Clear tap index k to 0 and go to UPDATE. If i_adapt_en=0, o_err still updates and the state stays IDLE.
  - UPDATE, one tap per cycle, k = 0..NUM_TAPS-1:
    - gI = eI*xI + eQ*xQ
    - gQ = eQ*xI - eI*xQ
    - The products are S(21,16) and the sums S(22,16).
    - Align each sum to NBF_TAPS fraction bits, arithmetic shift right by MU_SHIFT (floor), and add to working tap k.
    - Saturate the result to NBT_TAPS: max 2^(NBT_TAPS-1)-1, min -2^(NBT_TAPS-1).
    - Leave UPDATE after k = NUM_TAPS-1.
  - COMMIT: copy all working taps to o_taps in a single cycle, then go to IDLE.
- Timing: strobe at cycle 0; o_busy is high in cycles 1..NUM_TAPS+1; new o_taps are visible from cycle NUM_TAPS+2 (11 at default); IDLE again in cycle NUM_TAPS+2.
- Busy handling: i_sym_valid & i_adapt_en while not IDLE leaves snapshot, error and taps untouched and pulses o_drop for one cycle.
- i_adapt_en falling mid-update has no effect; the update in flight completes.
- Reset mid-UPDATE returns immediately to the reset values and discards the partial update.

Optional Feature:
- Macro FSE_LMS_LEAK_EN.
- Defined: each UPDATE step computes w_k <= sat(w_k - (w_k >>> LEAK_SHIFT) + delta_k) (leaky LMS).
- Undefined: plain LMS as described above; the LEAK_SHIFT parameter is unused.

Decomposition:
- Package fse_pkg: NUM_TAPS and all widths (NBT/NBF for IN, EQ, TAPS); derived product and gradient widths; CENTER_TAP index; DEC_LEVEL; FSM state enum.
- One sub-module, fse_lms_tap_upd (combinational): error × conj(x), alignment, mu shift, optional leak, saturation. Instantiated once and shared across taps by the index k.

Test Plan:
- Reset: o_taps_I tap4 = 33554432, all other taps 0, o_busy=0, o_err=0.
- Adaptation off: i_adapt_en=0, y=(100,0), i_sym_valid pulse -> o_err=(262,362), taps unchanged, o_busy stays 0.
- Single update: only x4 nonzero at (64,0), y=(100,0), strobe -> o_busy high 10 cycles; at cycle 11, tap4 I = 33554432+2096, tap4 Q = 2896, all other taps unchanged.
- Drop: second strobe 3 cycles after the first -> o_drop pulses once; final taps equal the single-update result.
- Saturation: MU_SHIFT=0, x4=(-128,0), y=(-2048,0), two updates -> tap4 I = -134217728 with no wrap; tap4 Q = -47448064.
- Reset mid-UPDATE: assert i_reset_n=0 at cycle 5 -> o_busy=0 immediately, taps return to reset values, next strobe updates normally.
